// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared RV32I fetch constants and sequencer state encoding
package rv32i_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [XLEN-1:0] DEFAULT_INC          = 32'd4;

    typedef logic [1:0] pc_state_t;

    localparam pc_state_t ST_BOOT  = 2'd0;
    localparam pc_state_t ST_FETCH = 2'd1;
    localparam pc_state_t ST_HOLD  = 2'd2;
    localparam pc_state_t ST_TRAP  = 2'd3;

endpackage

// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - fetch-side handshake bundle of the pc sequencer
interface pc_sequencer_if;
    import rv32i_pkg::*;

    logic            stall_i;
    logic            redirect_i;
    logic [XLEN-1:0] redirect_pc_i;
    logic            imem_ack_i;
    logic            imem_req_o;
    logic [XLEN-1:0] imem_addr_o;
    logic            fetch_valid_o;
    logic [XLEN-1:0] fetch_pc_o;
    logic [XLEN-1:0] fetch_pc_plus4_o;
    logic            misaligned_o;

    // master: the sequencer itself; slave: pipeline/memory side driving it
    modport master (
        input  stall_i, redirect_i, redirect_pc_i, imem_ack_i,
        output imem_req_o, imem_addr_o, fetch_valid_o, fetch_pc_o,
        output fetch_pc_plus4_o, misaligned_o
    );

    modport slave (
        output stall_i, redirect_i, redirect_pc_i, imem_ack_i,
        input  imem_req_o, imem_addr_o, fetch_valid_o, fetch_pc_o,
        input  fetch_pc_plus4_o, misaligned_o
    );

endinterface

// File: rtl/pcAdder.sv
// rtl/pcAdder.sv - pc incrementer, wraps modulo 2^XLEN
module pcAdder
    import rv32i_pkg::*;
(
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] y
);

    assign y = a + b;

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - instruction fetch pc sequencer with stall, redirect and misalignment trap
module pc_sequencer
    import rv32i_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter logic [XLEN-1:0] INC          = DEFAULT_INC
) (
    input  logic            clk,
    input  logic            rst,
    pc_sequencer_if.master  bus
);

    pc_state_t       state_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_next;
    logic            redirect_take;
    logic            redirect_bad;

    pcAdder u_pc_adder (
        .a (pc_q),
        .b (INC),
        .y (pc_next)
    );

    assign bus.imem_req_o  = (state_q == ST_FETCH);
    assign bus.imem_addr_o = pc_q;

    // BOOT never honours a redirect; everywhere else it outranks stall and ack
    assign redirect_take = bus.redirect_i && (state_q != ST_BOOT);
    assign redirect_bad  = |bus.redirect_pc_i[1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q              <= ST_BOOT;
            pc_q                 <= RESET_VECTOR;
            bus.fetch_valid_o    <= 1'b0;
            bus.fetch_pc_o       <= '0;
            bus.fetch_pc_plus4_o <= '0;
            bus.misaligned_o     <= 1'b0;
        end else if (state_q == ST_BOOT) begin
            state_q <= ST_FETCH;
        end else if (redirect_take) begin
            bus.fetch_valid_o <= 1'b0;
            if (redirect_bad) begin
                bus.misaligned_o <= 1'b1;
                state_q          <= ST_TRAP;
            end else begin
                pc_q             <= bus.redirect_pc_i;
                bus.misaligned_o <= 1'b0;
                state_q          <= ST_FETCH;
            end
        end else if (state_q == ST_FETCH) begin
            if (bus.stall_i) begin
                state_q <= ST_HOLD;
            end else if (bus.imem_ack_i) begin
                pc_q                 <= pc_next;
                bus.fetch_valid_o    <= 1'b1;
                bus.fetch_pc_o       <= pc_q;
                bus.fetch_pc_plus4_o <= pc_next;
            end else begin
                bus.fetch_valid_o <= 1'b0;
            end
        end else if (state_q == ST_HOLD) begin
            // leaving HOLD drops the held instruction so decode never sees it twice
            if (!bus.stall_i) begin
                state_q           <= ST_FETCH;
                bus.fetch_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - scoreboard bench for pc_sequencer
module tb_pc_sequencer;

    logic clk;
    logic rst;
    logic rst2;

    int checks;
    int errors;

    logic [31:0] exp_q[$];

    pc_sequencer_if bus ();
    pc_sequencer_if bus2 ();

    pc_sequencer u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    pc_sequencer #(.RESET_VECTOR(32'hFFFF_FFF8)) u_dut2 (
        .clk (clk),
        .rst (rst2),
        .bus (bus2.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Monitor: each fresh delivery on fetch_valid_o is matched against the scoreboard
    initial begin
        logic        prev_valid;
        logic [31:0] prev_pc;
        logic [31:0] e;
        prev_valid = 1'b0;
        prev_pc    = '0;
        forever begin
            @(negedge clk);
            if (bus.fetch_valid_o === 1'b1 && !(prev_valid && bus.fetch_pc_o === prev_pc)) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_delivery: got pc %h expected none at %0t",
                             bus.fetch_pc_o, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_fetch_pc", bus.fetch_pc_o, e);
                    chk("sb_fetch_pc_plus4", bus.fetch_pc_plus4_o, e + 32'd4);
                end
            end
            prev_valid = bus.fetch_valid_o;
            prev_pc    = bus.fetch_pc_o;
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        rst  = 1'b1;
        rst2 = 1'b1;
        bus.stall_i        = 1'b0;
        bus.redirect_i     = 1'b0;
        bus.redirect_pc_i  = '0;
        bus.imem_ack_i     = 1'b0;
        bus2.stall_i       = 1'b0;
        bus2.redirect_i    = 1'b0;
        bus2.redirect_pc_i = '0;
        bus2.imem_ack_i    = 1'b1;

        @(negedge clk);
        chk("rst_req", {31'd0, bus.imem_req_o}, 32'd0);
        chk("rst_addr", bus.imem_addr_o, 32'h0);
        chk("rst_valid", {31'd0, bus.fetch_valid_o}, 32'd0);
        chk("rst_fetch_pc", bus.fetch_pc_o, 32'h0);
        chk("rst_plus4", bus.fetch_pc_plus4_o, 32'h0);
        chk("rst_misaligned", {31'd0, bus.misaligned_o}, 32'd0);
        rst = 1'b0;

        cyc();
        chk("first_req", {31'd0, bus.imem_req_o}, 32'd1);
        chk("first_addr", bus.imem_addr_o, 32'h0);

        // sequential stream with ack held high
        bus.imem_ack_i = 1'b1;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h8);
        exp_q.push_back(32'hC);
        cyc();
        chk("seq_addr1", bus.imem_addr_o, 32'h4);
        cyc();
        chk("seq_addr2", bus.imem_addr_o, 32'h8);
        cyc();
        cyc();
        chk("seq_addr4", bus.imem_addr_o, 32'h10);

        // three-cycle stall at pc 0x10 with ack still high
        bus.stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("stall_req", {31'd0, bus.imem_req_o}, 32'd0);
            chk("stall_fetch_pc", bus.fetch_pc_o, 32'hC);
            chk("stall_valid", {31'd0, bus.fetch_valid_o}, 32'd1);
        end
        bus.stall_i = 1'b0;
        cyc();
        chk("resume_req", {31'd0, bus.imem_req_o}, 32'd1);
        chk("resume_addr", bus.imem_addr_o, 32'h10);
        chk("resume_valid", {31'd0, bus.fetch_valid_o}, 32'd0);
        exp_q.push_back(32'h10);
        exp_q.push_back(32'h14);
        cyc();
        cyc();
        chk("resume_addr2", bus.imem_addr_o, 32'h18);

        // redirect coincident with ack and stall
        bus.stall_i       = 1'b1;
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'h200;
        cyc();
        chk("redir_valid", {31'd0, bus.fetch_valid_o}, 32'd0);
        chk("redir_addr", bus.imem_addr_o, 32'h200);
        chk("redir_req", {31'd0, bus.imem_req_o}, 32'd1);
        bus.stall_i    = 1'b0;
        bus.redirect_i = 1'b0;
        exp_q.push_back(32'h200);
        cyc();
        chk("redir_next_addr", bus.imem_addr_o, 32'h204);

        bus.imem_ack_i = 1'b0;
        cyc();
        chk("noack_valid", {31'd0, bus.fetch_valid_o}, 32'd0);
        chk("noack_addr", bus.imem_addr_o, 32'h204);

        // misaligned target traps until an aligned redirect
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'h203;
        cyc();
        chk("trap_mis", {31'd0, bus.misaligned_o}, 32'd1);
        chk("trap_req", {31'd0, bus.imem_req_o}, 32'd0);
        chk("trap_addr", bus.imem_addr_o, 32'h204);
        bus.redirect_i = 1'b0;
        bus.imem_ack_i = 1'b1;
        cyc();
        chk("trap_hold_mis", {31'd0, bus.misaligned_o}, 32'd1);
        chk("trap_hold_req", {31'd0, bus.imem_req_o}, 32'd0);
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'h101;
        cyc();
        chk("trap_bad_mis", {31'd0, bus.misaligned_o}, 32'd1);
        chk("trap_bad_req", {31'd0, bus.imem_req_o}, 32'd0);
        bus.redirect_pc_i = 32'h100;
        cyc();
        chk("trap_exit_mis", {31'd0, bus.misaligned_o}, 32'd0);
        chk("trap_exit_req", {31'd0, bus.imem_req_o}, 32'd1);
        chk("trap_exit_addr", bus.imem_addr_o, 32'h100);
        bus.redirect_i = 1'b0;
        exp_q.push_back(32'h100);
        cyc();
        chk("trap_resume_addr", bus.imem_addr_o, 32'h104);

        // park at 0x40 with ack low, then reset asynchronously mid-cycle
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'h40;
        cyc();
        chk("park_addr", bus.imem_addr_o, 32'h40);
        chk("park_valid", {31'd0, bus.fetch_valid_o}, 32'd0);
        bus.redirect_i = 1'b0;
        bus.imem_ack_i = 1'b0;
        cyc();
        chk("park_req", {31'd0, bus.imem_req_o}, 32'd1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_req", {31'd0, bus.imem_req_o}, 32'd0);
        chk("async_addr", bus.imem_addr_o, 32'h0);
        chk("async_valid", {31'd0, bus.fetch_valid_o}, 32'd0);
        chk("async_fetch_pc", bus.fetch_pc_o, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        cyc();
        chk("restart_req", {31'd0, bus.imem_req_o}, 32'd1);
        chk("restart_addr", bus.imem_addr_o, 32'h0);
        bus.imem_ack_i = 1'b1;
        exp_q.push_back(32'h0);
        cyc();
        bus.imem_ack_i = 1'b0;
        cyc();
        cyc();
        chk("sb_drained", exp_q.size(), 32'd0);

        // wrap-around from a high reset vector
        @(negedge clk);
        rst2 = 1'b0;
        cyc();
        chk("wrap_addr0", bus2.imem_addr_o, 32'hFFFF_FFF8);
        chk("wrap_req", {31'd0, bus2.imem_req_o}, 32'd1);
        cyc();
        chk("wrap_addr1", bus2.imem_addr_o, 32'hFFFF_FFFC);
        chk("wrap_fetch_pc1", bus2.fetch_pc_o, 32'hFFFF_FFF8);
        cyc();
        chk("wrap_addr2", bus2.imem_addr_o, 32'h0000_0000);
        chk("wrap_fetch_pc2", bus2.fetch_pc_o, 32'hFFFF_FFFC);
        chk("wrap_plus4", bus2.fetch_pc_plus4_o, 32'h0000_0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h0000_0000, PC loaded on reset.
REQ-002 Parameter INC, default 32'd4, sequential PC increment.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 stall_i  input  1  hazard-unit fetch stall (StallF).
REQ-006 redirect_i  input  1  taken branch/jump from execute (PCSrcE).
REQ-007 redirect_pc_i  input  32  branch/jump target (PCTargetE).
REQ-008 imem_ack_i  input  1  instruction memory accepted the current request.
REQ-009 imem_req_o  output  1  fetch request valid.
REQ-010 imem_addr_o  output  32  fetch address; equals internal pc_q.
REQ-011 fetch_valid_o  output  1  registered; fetched instruction valid for decode.
REQ-012 fetch_pc_o  output  32  registered PC of the instruction flagged by fetch_valid_o.
REQ-013 fetch_pc_plus4_o  output  32  registered fetch_pc_o + INC (PCPlus4F to pipeline).
REQ-014 misaligned_o  output  1  registered; redirect target had bits [1:0] != 0.

Function
REQ-015 FSM states: BOOT, FETCH, HOLD, TRAP; one-hot or binary at implementer's choice.
REQ-016 BOOT: imem_req_o=0; unconditional transition to FETCH on the next edge.
REQ-017 FETCH: imem_req_o=1; imem_addr_o=pc_q; imem_req_o and imem_addr_o stay stable until imem_ack_i, except on redirect.
REQ-018 FETCH with imem_ack_i=1, stall_i=0, redirect_i=0: pc_q <= pc_q+INC; fetch_valid_o <= 1; fetch_pc_o <= pc_q; fetch_pc_plus4_o <= pc_q+INC.
REQ-019 FETCH with imem_ack_i=0: pc_q held; fetch_valid_o <= 0.
REQ-020 stall_i=1 (no redirect), from FETCH or HOLD: enter or stay in HOLD; imem_req_o=0; pc_q, fetch_valid_o, fetch_pc_o and fetch_pc_plus4_o held; a coincident ack is ignored.
REQ-021 HOLD with stall_i=0: return to FETCH and re-issue the request at the held pc_q.
REQ-022 Redirect has priority over stall and ack, in every state except BOOT: pc_q <= redirect_pc_i; fetch_valid_o <= 0 (flush); a coincident ack is discarded; next state FETCH.
REQ-023 Redirect with redirect_pc_i[1:0] != 0: pc_q unchanged; misaligned_o <= 1; fetch_valid_o <= 0; next state TRAP.
REQ-024 TRAP: imem_req_o=0; misaligned_o held at 1; exit only on an aligned redirect, which clears misaligned_o and enters FETCH at the target. A misaligned redirect in TRAP keeps TRAP.
REQ-025 Arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000, with no flag.
REQ-026 Latency: ack at edge N gives fetch_valid_o=1 after edge N; the next request address appears in the same cycle.
REQ-027 Throughput: with ack held high and no stall, one instruction is delivered per cycle.

Reset
REQ-028 On rst=1, asynchronously: state=BOOT, pc_q=RESET_VECTOR, fetch_valid_o=0, fetch_pc_o=0, fetch_pc_plus4_o=0, misaligned_o=0, imem_req_o=0.
REQ-029 Reset asserted mid-request abandons the request; no instruction from that request is ever flagged valid.
REQ-030 First request after deassertion: imem_addr_o=RESET_VECTOR, in the second cycle after rst falls.

Structure
REQ-031 Shared package rv32i_pkg holds XLEN=32, the default RESET_VECTOR, INC, and the FSM state typedef.
REQ-032 One sub-module: the existing pcAdder, instanced with b=INC, computes pc_q+INC; no other adder is used for the increment.

Verification
REQ-033 Reset release, ack always high -> imem_addr_o sequence 0x0, 0x4, 0x8; fetch_pc_o 0x0, 0x4 with fetch_valid_o=1 every cycle.
REQ-034 stall_i high for 3 cycles at pc 0x10, with ack high -> imem_req_o=0, fetch_pc_o frozen at 0xC; resume at 0x10 with no skip or duplicate.
REQ-035 redirect_i=1, target 0x200, coincident with ack and stall -> next fetch_valid_o=0, then imem_addr_o=0x200, then fetch_pc_o=0x200.
REQ-036 Redirect to 0x203 -> misaligned_o=1, imem_req_o=0 until a redirect to 0x100; then misaligned_o=0 and fetch resumes at 0x100.
REQ-037 RESET_VECTOR=0xFFFF_FFF8, ack high -> addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
REQ-038 rst pulsed asynchronously mid-cycle with ack low at pc 0x40 -> outputs reset immediately; no fetch_valid_o for 0x40; restart at RESET_VECTOR.
